// File: rtl/corefifo_ptr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : corefifo_ptr_ctrl_pkg
// Brief    : Shared helpers for the FIFO pointer controller: pointer width
//            and Gray encoding.
// Revision : 1.0 - initial release
// ============================================================================
package corefifo_ptr_ctrl_pkg;

    // A pointer carries one extra wrap bit on top of the RAM address.
    function automatic int unsigned ptr_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    // Binary to reflected Gray code; callers truncate to their pointer width.
    function automatic logic [31:0] gray_enc(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/corefifo_gray_ptr.sv
`default_nettype none
// ============================================================================
// Module   : corefifo_gray_ptr
// Brief    : Wrapping binary pointer with a registered Gray-coded copy that
//            updates on the same edge as the binary value.
// Revision : 1.0 - initial release
// ============================================================================
module corefifo_gray_ptr
    import corefifo_ptr_ctrl_pkg::*;
#(
    parameter int ADDRWIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [ADDRWIDTH:0] bin,
    output logic [ADDRWIDTH:0] gray
);

    localparam int unsigned PTRW = ptr_width(ADDRWIDTH);

    logic [PTRW-1:0] bin_q;
    logic [PTRW-1:0] bin_d;
    logic [PTRW-1:0] gray_q;
    logic [PTRW-1:0] gray_d;

    // Next pointer value; Gray is encoded from the next binary value so both
    // registers always describe the same pointer.
    always_comb begin
        bin_d  = bin_q;
        if (inc) begin
            bin_d = bin_q + {{(PTRW-1){1'b0}}, 1'b1};
        end
        gray_d = PTRW'(gray_enc(32'(bin_d)));
    end

    // Pointer registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;

endmodule
`default_nettype wire

// File: rtl/corefifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : corefifo_ptr_ctrl
// Brief    : Synchronous FIFO pointer/flag controller. Qualifies write/read
//            requests against registered full/empty, drives RAM strobes and
//            addresses, and registers occupancy plus status flags.
//            Optional macro COREFIFO_ERR_FLAGS_EN adds overflow/underflow
//            one-cycle error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module corefifo_ptr_ctrl
    import corefifo_ptr_ctrl_pkg::*;
#(
    parameter int ADDRWIDTH  = 3,
    parameter int AFULL_VAL  = 6,
    parameter int AEMPTY_VAL = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic                 re,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic [ADDRWIDTH:0]   wgray,
    output logic [ADDRWIDTH:0]   rgray,
    output logic                 full,
    output logic                 empty,
    output logic                 afull,
    output logic                 aempty,
`ifdef COREFIFO_ERR_FLAGS_EN
    output logic                 overflow,
    output logic                 underflow,
`endif
    output logic [ADDRWIDTH:0]   count
);

    localparam int unsigned     PTRW     = ptr_width(ADDRWIDTH);
    localparam logic [PTRW-1:0] DEPTH_C  = PTRW'(1) << ADDRWIDTH;
    localparam logic [PTRW-1:0] AFULL_C  = PTRW'(AFULL_VAL);
    localparam logic [PTRW-1:0] AEMPTY_C = PTRW'(AEMPTY_VAL);

    logic [PTRW-1:0] wbin;
    logic [PTRW-1:0] rbin;
    logic [PTRW-1:0] occ_d;
    logic [PTRW-1:0] count_q;
    logic            full_q;
    logic            empty_q;
    logic            afull_q;
    logic            aempty_q;
    logic            full_d;
    logic            empty_d;
    logic            afull_d;
    logic            aempty_d;

    // Strobes come from registered flags only; reset suppresses both so an
    // in-flight operation is dropped.
    assign mem_we = we & ~full_q  & ~reset;
    assign mem_re = re & ~empty_q & ~reset;

    corefifo_gray_ptr #(.ADDRWIDTH(ADDRWIDTH)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .inc   (mem_we),
        .bin   (wbin),
        .gray  (wgray)
    );

    corefifo_gray_ptr #(.ADDRWIDTH(ADDRWIDTH)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .inc   (mem_re),
        .bin   (rbin),
        .gray  (rgray)
    );

    assign waddr = wbin[ADDRWIDTH-1:0];
    assign raddr = rbin[ADDRWIDTH-1:0];

    // Next occupancy. The pointer difference always equals the registered
    // count, so using it keeps count and the pointer relation in lockstep.
    always_comb begin
        occ_d    = (wbin - rbin) + PTRW'(mem_we) - PTRW'(mem_re);
        full_d   = (occ_d == DEPTH_C);
        empty_d  = (occ_d == '0);
        afull_d  = (occ_d >= AFULL_C);
        aempty_d = (occ_d <= AEMPTY_C);
    end

    // Registered occupancy and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            count_q  <= occ_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign count  = count_q;
    assign full   = full_q;
    assign empty  = empty_q;
    assign afull  = afull_q;
    assign aempty = aempty_q;

`ifdef COREFIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // One-cycle pulse after a request that was rejected by a full/empty flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= we & full_q;
            underflow_q <= re & empty_q;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_corefifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_corefifo_ptr_ctrl
// Brief    : Self-checking bench for corefifo_ptr_ctrl (ADDRWIDTH=3,
//            AFULL_VAL=6, AEMPTY_VAL=2). Honours COREFIFO_ERR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_corefifo_ptr_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic          mem_we, mem_re;
    logic [AW-1:0] waddr, raddr;
    logic [AW:0]   wgray, rgray, count;
    logic          full, empty, afull, aempty;
`ifdef COREFIFO_ERR_FLAGS_EN
    logic          overflow, underflow;
`endif

    corefifo_ptr_ctrl #(.ADDRWIDTH(AW), .AFULL_VAL(AF), .AEMPTY_VAL(AE)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .re        (re),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .waddr     (waddr),
        .raddr     (raddr),
        .wgray     (wgray),
        .rgray     (rgray),
        .full      (full),
        .empty     (empty),
        .afull     (afull),
        .aempty    (aempty),
`ifdef COREFIFO_ERR_FLAGS_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: occupancy as an integer, pointers as free-running
    // integers reduced modulo 16 when compared.
    int m_cnt  = 0;
    int m_wp   = 0;
    int m_rp   = 0;
    int m_ovf  = 0;
    int m_unf  = 0;

    function automatic int gray_of(input int p);
        int b;
        b = p % (2 * DEPTH);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Compare all registered outputs against the model.
    task automatic chk_state(input string tag);
        chk({tag, ".count"},  int'(count),  m_cnt);
        chk({tag, ".full"},   int'(full),   int'(m_cnt == DEPTH));
        chk({tag, ".empty"},  int'(empty),  int'(m_cnt == 0));
        chk({tag, ".afull"},  int'(afull),  int'(m_cnt >= AF));
        chk({tag, ".aempty"}, int'(aempty), int'(m_cnt <= AE));
        chk({tag, ".waddr"},  int'(waddr),  m_wp % DEPTH);
        chk({tag, ".raddr"},  int'(raddr),  m_rp % DEPTH);
        chk({tag, ".wgray"},  int'(wgray),  gray_of(m_wp));
        chk({tag, ".rgray"},  int'(rgray),  gray_of(m_rp));
`ifdef COREFIFO_ERR_FLAGS_EN
        chk({tag, ".overflow"},  int'(overflow),  m_ovf);
        chk({tag, ".underflow"}, int'(underflow), m_unf);
`endif
    endtask

    // One clock cycle: drive after the falling edge, check strobes, then
    // advance the model on the rising edge and check registered outputs.
    task automatic cyc(input logic w, input logic r, input logic rst, input string tag);
        bit aw, ar;
        @(negedge clk);
        we = w; re = r; reset = rst;
        #1;
        aw = w && !rst && (m_cnt < DEPTH);
        ar = r && !rst && (m_cnt > 0);
        chk({tag, ".mem_we"}, int'(mem_we), int'(aw));
        chk({tag, ".mem_re"}, int'(mem_re), int'(ar));
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_ovf = int'(w && m_cnt == DEPTH);
            m_unf = int'(r && m_cnt == 0);
            m_cnt = m_cnt + int'(aw) - int'(ar);
            m_wp  = (m_wp + int'(aw)) % (2 * DEPTH);
            m_rp  = (m_rp + int'(ar)) % (2 * DEPTH);
        end
        #1;
        chk_state(tag);
    endtask

    typedef struct {
        logic w;
        logic r;
        int   e_cnt;
        logic e_full;
        logic e_empty;
        logic e_afull;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic w, input logic r, input int c,
                                input logic f, input logic e, input logic af);
        vec_t v;
        v.w = w; v.r = r; v.e_cnt = c; v.e_full = f; v.e_empty = e; v.e_afull = af;
        return v;
    endfunction

    initial begin
        // Fill to full, push against full, both at full, drain, both at empty,
        // read against empty.
        for (int i = 1; i <= 8; i++) vt.push_back(mk(1, 0, i, i == 8, 0, i >= 6));
        vt.push_back(mk(1, 0, 8, 1, 0, 1));
        vt.push_back(mk(1, 1, 7, 0, 0, 1));
        for (int i = 6; i >= 0; i--) vt.push_back(mk(0, 1, i, 0, i == 0, i >= 6));
        vt.push_back(mk(0, 1, 0, 0, 1, 0));
        vt.push_back(mk(1, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 1, 0));

        // Reset state
        cyc(0, 0, 1, "rst");
        cyc(0, 0, 1, "rst2");

        // Table-driven vectors with explicit expectations
        for (int i = 0; i < vt.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cyc(vt[i].w, vt[i].r, 0, tag);
            chk({tag, ".tcount"}, int'(count), vt[i].e_cnt);
            chk({tag, ".tfull"},  int'(full),  int'(vt[i].e_full));
            chk({tag, ".tempty"}, int'(empty), int'(vt[i].e_empty));
            chk({tag, ".tafull"}, int'(afull), int'(vt[i].e_afull));
            if (i == 7) chk("fill8.wgray", int'(wgray), 12);
        end

        // Steady occupancy of 3 with simultaneous traffic across the wrap
        cyc(0, 0, 1, "rst3");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, "pre3");
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, "both");
            chk("both.count3", int'(count), 3);
        end
        chk("wrap.wptr", m_wp, 7);

        // Reset with traffic at count 5
        cyc(0, 0, 1, "rst4");
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, "pre5");
        cyc(1, 1, 1, "rstbusy");
        chk("rstbusy.count", int'(count), 0);
        chk("rstbusy.empty", int'(empty), 1);
        chk("rstbusy.wgray", int'(wgray), 0);
        chk("rstbusy.rgray", int'(rgray), 0);
        // First write right after reset release
        cyc(1, 0, 0, "first");
        chk("first.count", int'(count), 1);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic w, r, x;
            w = logic'($urandom_range(0, 99) < 55);
            r = logic'($urandom_range(0, 99) < 45);
            x = logic'($urandom_range(0, 99) < 2);
            cyc(w, r, x, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
